multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Iterative signed multiply/divide unit with its own control FSM: accepts one issue from the execute stage, runs a 32-iteration shift-add or shift-subtract datapath, fixes signs, and returns a tagged result to the writeback path. Its `running` output is the pipeline's multdiv stall source. Its `data_resultRDY`/`o_rd` pair tells writeback when and where to commit. It replaces ad-hoc stall tracking in the processor with one owned sequencer.

## Interface
- `WIDTH`, default 32: operand/result width. Iteration count equals `WIDTH`.
- `TAGW`, default 5: destination-register tag width.
- `clock`, in, 1: single clock. Everything is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `ctrl_MULT`, in, 1: issue-multiply pulse, sampled on the edge.
- `ctrl_DIV`, in, 1: issue-divide pulse, sampled on the edge.
- `data_operandA`, in, `WIDTH`: multiplicand or dividend (signed). Valid in the issue cycle only.
- `data_operandB`, in, `WIDTH`: multiplier or divisor (signed). Valid in the issue cycle only.
- `i_rd`, in, `TAGW`: destination tag, captured at issue.
- `flush`, in, 1: abort the in-flight operation (branch/jump squash).
- `running`, out, 1: operation in progress. The pipeline stalls on it.
- `data_result`, out, `WIDTH`: result. Valid only while `data_resultRDY` is high.
- `data_exception`, out, 1: overflow or divide-by-zero. Valid while `data_resultRDY` is high.
- `data_resultRDY`, out, 1: one-cycle result strobe.
- `o_rd`, out, `TAGW`: tag captured at issue. Held until the next issue.

## Operation
- **States.**
  - IDLE: waits for an issue.
  - RUN: 32 iterations driven by 6-bit counter `cnt`.
  - FIX: sign correction and exception evaluation.
  - DONE: result strobe.
- **Issue.** Accepted only in IDLE or DONE, when `ctrl_MULT|ctrl_DIV` is high and `flush` is low.
  - Captures `|A|`, `|B|`, `sA`, `sB`, op, and `i_rd`.
  - Clears `cnt`, then the FSM goes to RUN.
  - If both ctrl bits are high, MULT is performed.
  - Issue pulses in RUN or FIX are ignored.
- **RUN.**
  - Performs one datapath step per cycle and increments `cnt`.
  - When `cnt==WIDTH-1` the FSM goes to FIX next.
- **Multiply.** Unsigned shift-add of magnitudes into a 2·`WIDTH` product.
  - FIX negates the product if `sA^sB`.
  - `data_result` is the low `WIDTH` bits.
  - Exception if the upper `WIDTH+1` bits of the signed product are not all equal.
- **Divide.** Unsigned restoring division of magnitudes.
  - FIX negates the quotient if `sA^sB`, giving truncation toward zero. The remainder is discarded.
  - Divisor 0: result 0, exception 1.
  - `0x80000000 / -1`: result `0x80000000`, exception 1.
- **FIX to DONE.** DONE asserts `data_resultRDY` for exactly one cycle.
  - Next state is IDLE, or RUN if a new issue is accepted in the same cycle.
- **Flush.** Flush in RUN, FIX or DONE forces IDLE next cycle.
  - No strobe occurs. A strobe already high in that same DONE cycle is still emitted.
  - Flush with an issue in the same cycle drops the issue.
- **Reset.** Forces IDLE from any state.
  - Outputs on reset: `running`=0, `data_resultRDY`=0, `data_exception`=0, `data_result`=0, `o_rd`=0.
  - Datapath registers are cleared. There is no partial result.

## Timing
- Issue is sampled at edge t.
  - RUN occupies cycles t+1..t+32, FIX is t+33, DONE is t+34.
  - Latency is 34 cycles from issue to `data_resultRDY`.
- `running` is high in RUN and FIX, i.e. cycles t+1..t+33. It is low in IDLE and DONE.
- Back-to-back: an issue in the DONE cycle starts RUN on the next cycle. Throughput is 1 operation per 34 cycles.
- `data_result` and `data_exception` are registered in FIX and held steady through DONE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`MULTDIV_EARLY_OUT_EN` defined:**
  - At issue, if op is MULT and either operand is 0, or op is DIV and A is 0 with B nonzero, the FSM goes IDLE→DONE directly.
  - Result is 0, exception 0, strobe at t+1, and `running` never asserts.
  - Divide-by-zero still takes the full path.
- **Not defined:** every operation takes 34 cycles.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - the op encoding (`OP_MULT`, `OP_DIV`);
  - `MD_ITERS = 32`;
  - the `MIN_INT` constant.
- Sub-module `multdiv_iter_dp` is combinational plus registers.
  - It holds the accumulator, shift register and divisor, and performs one step per enable.
  - Its inputs are op, `load` and `step`.
- `multdiv_sequencer` owns the FSM, the counter, the sign and tag capture, the FIX logic and the outputs.

## Test plan
- MULT A=7, B=-6, `i_rd`=5 at t: `data_resultRDY` at t+34; result `0xFFFFFFD6` (-42), exception 0, `o_rd`=5; `running` high t+1..t+33.
- DIV A=-100, B=7: result -14 (`0xFFFFFFF2`), exception 0. DIV A=5, B=0: result 0, exception 1.
- MULT `0x00010000`×`0x00010000`: result 0, exception 1. DIV `0x80000000`/-1: result `0x80000000`, exception 1.
- Issue MULT, then assert `flush` at t+10: IDLE at t+11 with `running` 0 and no strobe. A new DIV at t+12 completes at t+46.
- Issue in the DONE cycle: the second strobe comes 34 cycles later. `ctrl_DIV` pulses at t+5 are ignored. Asserting `reset` at t+20 clears all outputs next cycle.
- With `MULTDIV_EARLY_OUT_EN`: MULT 0×9 gives a strobe at t+1 with result 0 and `running` never high. Without it, the strobe comes at t+34.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package multdiv_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Operation selector captured at issue
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  // Default iteration count (one iteration per operand bit)
  localparam int MD_ITERS = 32;

  // Most negative 32-bit two's-complement value
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

endpackage

// File: rtl/multdiv_iter_dp.sv
// One-bit-per-cycle unsigned datapath shared by multiply and divide.
//   Multiply: {acc, sr} is the 2*WIDTH product, dvs holds the multiplicand,
//             sr initially holds the multiplier and is consumed LSB first.
//   Divide:   acc is the partial remainder, sr shifts the dividend out MSB
//             first and the quotient bits in LSB first, dvs holds the divisor.
module multdiv_iter_dp
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  md_op_e           op_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mag_a_i,
  input  logic [WIDTH-1:0] mag_b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sr_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide)
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {acc_q, sr_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvs_q};
    div_fits  = (div_shift >= {1'b0, dvs_q});

    acc_d = acc_q;
    sr_d  = sr_q;
    dvs_d = dvs_q;
    if (load_i) begin
      acc_d = '0;
      if (op_i == OP_MULT) begin
        sr_d  = mag_b_i;
        dvs_d = mag_a_i;
      end else begin
        sr_d  = mag_a_i;
        dvs_d = mag_b_i;
      end
    end else if (step_i) begin
      if (op_i == OP_MULT) begin
        acc_d = mul_sum[WIDTH:1];
        sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
      end else if (div_fits) begin
        // Partial remainder is always below the divisor, so WIDTH bits suffice
        acc_d = div_trial[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers, cleared on reset so no stale partial result survives
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      sr_q  <= '0;
      dvs_q <= '0;
    end else begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
      dvs_q <= dvs_d;
    end
  end

  assign acc_o = acc_q;
  assign sr_o  = sr_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide sequencer: issue capture, WIDTH-step
// datapath run, sign fix-up with exception detection, tagged result strobe.
// Optional build macro MULTDIV_EARLY_OUT_EN: zero-operand multiplies and
// zero-dividend divides complete straight from issue without iterating.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS,
  parameter int TAGW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAGW-1:0]  i_rd,
  input  logic             flush,
  output logic             running,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAGW-1:0]  o_rd
);

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [5:0]       cnt_q;
  logic             neg_q;
  logic             bzero_q;
  logic [TAGW-1:0]  rd_q;
  logic             running_q;
  logic             rdy_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  md_op_e           issue_op;
  logic             issue_ok;
  logic             eo_hit;
  md_op_e           dp_op;
  logic             dp_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] dp_acc, dp_sr;

  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   fix_result_d;
  logic               fix_exc_d;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] fn_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  // Signed product overflows WIDTH when its top WIDTH+1 bits are not all equal
  function automatic logic fn_mul_ovf(input logic [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  // Issue decode; MULT wins when both request bits are set
  always_comb begin
    issue_op = ctrl_MULT ? OP_MULT : OP_DIV;
    issue_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
               (ctrl_MULT || ctrl_DIV) && !flush;
    mag_a    = fn_mag(data_operandA);
    mag_b    = fn_mag(data_operandB);
    dp_op    = issue_ok ? issue_op : op_q;
    dp_step  = (state_q == ST_RUN) && !flush;
  end

`ifdef MULTDIV_EARLY_OUT_EN
  // Results known to be zero skip the iteration; divide-by-zero still runs
  assign eo_hit = (issue_op == OP_MULT)
                ? ((data_operandA == '0) || (data_operandB == '0))
                : ((data_operandA == '0) && (data_operandB != '0));
`else
  assign eo_hit = 1'b0;
`endif

  multdiv_iter_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock   (clock),
    .reset   (reset),
    .op_i    (dp_op),
    .load_i  (issue_ok),
    .step_i  (dp_step),
    .mag_a_i (mag_a),
    .mag_b_i (mag_b),
    .acc_o   (dp_acc),
    .sr_o    (dp_sr)
  );

  // Sign correction and exception evaluation applied in the FIX state
  always_comb begin
    prod_u = {dp_acc, dp_sr};
    prod_s = neg_q ? ('0 - prod_u) : prod_u;
    quot_s = neg_q ? ('0 - dp_sr) : dp_sr;
    if (op_q == OP_MULT) begin
      fix_result_d = prod_s[WIDTH-1:0];
      fix_exc_d    = fn_mul_ovf(prod_s);
    end else if (bzero_q) begin
      fix_result_d = '0;
      fix_exc_d    = 1'b1;
    end else begin
      // A positive quotient with the top bit set is only MIN / -1
      fix_result_d = quot_s;
      fix_exc_d    = !neg_q && dp_sr[WIDTH-1];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      bzero_q   <= 1'b0;
      rd_q      <= '0;
      running_q <= 1'b0;
      rdy_q     <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (issue_ok) begin
            op_q    <= issue_op;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_q <= (data_operandB == '0);
            rd_q    <= i_rd;
            cnt_q   <= '0;
            if (eo_hit) begin
              state_q  <= ST_DONE;
              rdy_q    <= 1'b1;
              result_q <= '0;
              exc_q    <= 1'b0;
            end else begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          running_q <= 1'b0;
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            state_q  <= ST_DONE;
            rdy_q    <= 1'b1;
            result_q <= fix_result_d;
            exc_q    <= fix_exc_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign running        = running_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign o_rd           = rd_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: latency, running window, signed
// results, exceptions, flush, back-to-back issue, ignored pulses and reset.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [4:0]  i_rd = '0;
  logic        flush = 1'b0;
  logic        running;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  o_rd;

  int n_cmp = 0;
  int n_err = 0;

  int          lat, run_cnt, extra;
  logic [31:0] res;
  logic        exc;
  logic [4:0]  tag;
  bit          seen_rdy;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .i_rd           (i_rd),
    .flush          (flush),
    .running        (running),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .o_rd           (o_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive an issue so that it is sampled on the next rising edge
  task automatic issue_now(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    data_operandA = a;
    data_operandB = b;
    i_rd          = rd;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'hDEAD_BEEF;
    i_rd          = '0;
  endtask

  // Count edges after the issue edge until the strobe, tallying running cycles
  task automatic wait_done(output int l, output int rc, output logic [31:0] r,
                           output logic e, output logic [4:0] t);
    l  = 0;
    rc = 0;
    while (!data_resultRDY && l < 100) begin
      if (running) rc++;
      @(posedge clock);
      #1;
      l++;
    end
    r = data_result;
    e = data_exception;
    t = o_rd;
  endtask

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clock);
    issue_now(is_div, a, b, rd);
    wait_done(lat, run_cnt, res, exc, tag);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    // Reset state
    check("rst_running", 64'(running), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_exc", 64'(data_exception), 64'd0);
    check("rst_result", 64'(data_result), 64'd0);
    check("rst_ord", 64'(o_rd), 64'd0);
    reset = 1'b0;

    // 7 * -6 = -42, strobe in cycle t+34 (33 edges after the issue edge)
    run_op(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd5);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_running_cycles", 64'(run_cnt), 64'd33);
    check("mul_result", 64'(res), 64'hFFFF_FFD6);
    check("mul_exc", 64'(exc), 64'd0);
    check("mul_ord", 64'(tag), 64'd5);
    check("mul_running_in_done", 64'(running), 64'd0);
    @(posedge clock);
    #1;
    check("mul_strobe_width", 64'(data_resultRDY), 64'd0);
    check("mul_ord_held", 64'(o_rd), 64'd5);

    // -100 / 7 = -14 (truncation toward zero)
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd3);
    check("div_result", 64'(res), 64'hFFFF_FFF2);
    check("div_exc", 64'(exc), 64'd0);
    check("div_ord", 64'(tag), 64'd3);

    // 5 / 0
    run_op(1'b1, 32'd5, 32'd0, 5'd4);
    check("div0_lat", 64'(lat), 64'd33);
    check("div0_result", 64'(res), 64'd0);
    check("div0_exc", 64'(exc), 64'd1);

    // 0x10000 * 0x10000 = 2^32 overflows
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6);
    check("mulovf_result", 64'(res), 64'd0);
    check("mulovf_exc", 64'(exc), 64'd1);

    // MIN_INT / -1
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    check("divovf_result", 64'(res), 64'h8000_0000);
    check("divovf_exc", 64'(exc), 64'd1);

    // -7 * -9 = 63, both bits set selects MULT
    @(negedge clock);
    ctrl_DIV = 1'b1;
    issue_now(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 5'd10);
    wait_done(lat, run_cnt, res, exc, tag);
    check("both_result", 64'(res), 64'd63);
    check("both_exc", 64'(exc), 64'd0);

    // Flush sampled at edge t+10, then DIV issued at edge t+12
    @(negedge clock);
    issue_now(1'b0, 32'd3, 32'd4, 5'd9);
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_running", 64'(running), 64'd0);
    check("flush_rdy", 64'(data_resultRDY), 64'd0);
    @(posedge clock);
    #1;
    check("flush_idle_rdy", 64'(data_resultRDY), 64'd0);
    run_op(1'b1, 32'd1000, 32'd33, 5'd11);
    check("postflush_lat", 64'(lat), 64'd33);
    check("postflush_result", 64'(res), 64'd30);
    check("postflush_ord", 64'(tag), 64'd11);

    // Back-to-back: second issue sampled at the edge that ends the DONE cycle
    run_op(1'b0, 32'd3, 32'd4, 5'd1);
    check("b2b_first_result", 64'(res), 64'd12);
    issue_now(1'b1, 32'd100, 32'hFFFF_FFF9, 5'd2);
    wait_done(lat, run_cnt, res, exc, tag);
    check("b2b_second_lat", 64'(lat), 64'd33);
    check("b2b_second_result", 64'(res), 64'hFFFF_FFF2);
    check("b2b_second_ord", 64'(tag), 64'd2);

    // A DIV pulse during RUN is ignored
    @(negedge clock);
    issue_now(1'b0, 32'd3, 32'd4, 5'd12);
    repeat (4) @(posedge clock);
    #1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd0;
    i_rd          = 5'd31;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    wait_done(extra, run_cnt, res, exc, tag);
    check("ignore_lat", 64'(extra + 5), 64'd33);
    check("ignore_result", 64'(res), 64'd12);
    check("ignore_exc", 64'(exc), 64'd0);
    check("ignore_ord", 64'(tag), 64'd12);

    // Flush together with an issue in the DONE cycle drops the issue
    run_op(1'b0, 32'd2, 32'd2, 5'd13);
    check("flushdone_result", 64'(res), 64'd4);
    flush = 1'b1;
    issue_now(1'b0, 32'd5, 32'd5, 5'd14);
    flush = 1'b0;
    check("flushdone_running", 64'(running), 64'd0);
    check("flushdone_ord", 64'(o_rd), 64'd13);
    seen_rdy = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen_rdy = 1'b1;
    end
    check("flushdone_no_strobe", 64'(seen_rdy), 64'd0);

    // Reset asserted at t+20 clears every output
    @(negedge clock);
    issue_now(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd7);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_running", 64'(running), 64'd0);
    check("midrst_rdy", 64'(data_resultRDY), 64'd0);
    check("midrst_exc", 64'(data_exception), 64'd0);
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_ord", 64'(o_rd), 64'd0);

    // Zero multiplicand: early-out when enabled, full latency otherwise
    run_op(1'b0, 32'd0, 32'd9, 5'd15);
`ifdef MULTDIV_EARLY_OUT_EN
    check("zero_mul_lat", 64'(lat), 64'd0);
    check("zero_mul_running_cycles", 64'(run_cnt), 64'd0);
`else
    check("zero_mul_lat", 64'(lat), 64'd33);
    check("zero_mul_running_cycles", 64'(run_cnt), 64'd33);
`endif
    check("zero_mul_result", 64'(res), 64'd0);
    check("zero_mul_exc", 64'(exc), 64'd0);
    check("zero_mul_ord", 64'(tag), 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
